freq_div_n: RTL and testbench
=============================

// Module: freq_div_n
// PURPOSE
//  Programmable integer clock divider; successor to the fixed divide-by-2 block.
//  Generates a divided square wave clk_out and a one-cycle period strobe tick, both
//  synchronous to clk_in. The divisor is changed at run time without glitches via a
//  shadow register that only updates at period boundaries. Used to derive slow
//  enables/clocks (baud, LED scan, debounce) from the system clock.
// PARAMETERS
//  WIDTH        8   width of divisor, duty and counter
//  DEFAULT_DIV  2   divisor loaded at reset; legal range 2..2**WIDTH-1
// PORTS
//  clk_in    in   1      system clock, all logic on rising edge
//  reset     in   1      synchronous, active-high reset
//  enable    in   1      1 = count; 0 = freeze all state
//  div_val   in   WIDTH  requested divisor N, sampled at period boundary only
//  clk_out   out  1      divided clock, registered, period N clk_in cycles
//  tick      out  1      registered 1-cycle pulse on the first cycle of each period
//  cur_div   out  WIDTH  divisor currently in effect (shadow register div_act)
// BEHAVIOUR
//  - Reset (reset=1 at posedge): cnt<=DEFAULT_DIV-1, div_act<=DEFAULT_DIV,
//    clk_out<=0, tick<=0. Reset wins over enable and over any boundary event.
//  - Clamp: N_in = (div_val<2) ? 2 : div_val. Values 0 and 1 behave as 2.
//  - High time H: H = div_act_next>>1 (floor(N/2)); low time N-H.
//  - Enabled edge, boundary (cnt==div_act-1): cnt<=0; div_act<=N_in; tick<=1;
//    clk_out<=1 (H>=1 always). H computed from the newly loaded divisor.
//  - Enabled edge, non-boundary: cnt<=cnt+1; tick<=0; clk_out<=((cnt+1)<H).
//  - First enabled edge after reset is a boundary: tick=1, clk_out=1 one edge later.
//  - enable=0: cnt, div_act, clk_out hold; tick<=0. Re-enabling resumes mid-period.
//  - div_val change mid-period: ignored until next boundary; current period completes
//    with old N (no runt/stretched pulses). cur_div updates on the boundary edge.
//  - Shrinking N: old period still completes; no counter overrun possible since cnt
//    compares against div_act, never div_val.
//  - Counter width WIDTH; max N=2**WIDTH-1; cnt never exceeds div_act-1.
//  - Reset asserted mid-period: next edge returns to reset state; prior period lost.
//  - Latency: div_val to effect = remainder of current period + 1 edge.
// CONFIGURATION
//  FREQ_DIV_DUTY_EN defined: adds input duty_val[WIDTH-1:0], sampled together with
//   div_val at the boundary; H = clamp(duty_val, 1, N_in-1). cur_duty not exported.
//  Not defined: no duty_val port; H = N>>1 as above.
// TESTING (clk_in period 40 ns)
//  1 reset 3 cycles, div_val=2, enable=1 -> clk_out 1,0,1,0...; tick every 2nd cycle;
//    cur_div=2.
//  2 div_val=5 -> after boundary clk_out high 2 / low 3 cycles, tick every 5 cycles;
//    cur_div=5 exactly at the boundary edge.
//  3 N=8, write div_val=3 at cnt=2 -> 5 more cycles of old period, then period 3
//    (high 1, low 2); no pulse shorter than 1 or longer than 8 cycles.
//  4 div_val=0 then 1 -> behaves as N=2; cur_div=2.
//  5 N=6, enable=0 for 4 cycles at cnt=3 -> clk_out/cnt frozen, tick=0; resumes
//    at cnt=4; reset pulse mid-period -> clk_out=0, cur_div=DEFAULT_DIV next edge.
//  6 FREQ_DIV_DUTY_EN: N=10, duty_val=3 -> high 3/low 7; duty_val=0 -> high 1;
//    duty_val=12 -> high 9.

Source files
------------

// File: rtl/freq_div_n.sv
// freq_div_n: programmable integer clock divider.
// Produces a registered divided clock (clk_out, period N cycles of clk_in) and a
// one-cycle strobe (tick) on the first cycle of each period. The requested
// divisor div_val is loaded into a shadow register only at a period boundary,
// so run-time changes never produce runt or stretched pulses.
// Optional build macro: FREQ_DIV_DUTY_EN adds duty_val, a programmable high
// time sampled together with div_val. Without it the high time is floor(N/2).
module freq_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_val,
`ifdef FREQ_DIV_DUTY_EN
    input  logic [WIDTH-1:0] duty_val,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(DEFAULT_DIV - 1);

    logic [WIDTH-1:0] cnt;      // position inside the current period, 0..div_act-1
    logic [WIDTH-1:0] div_act;  // divisor in effect for the current period
    logic [WIDTH-1:0] h_cur;    // high time of the current period
    logic [WIDTH-1:0] n_in;     // clamped requested divisor
    logic [WIDTH-1:0] cnt_inc;
    logic             boundary;

`ifdef FREQ_DIV_DUTY_EN
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_DIV / 2);

    logic [WIDTH-1:0] h_act;    // high time in effect, loaded with div_act
    logic [WIDTH-1:0] h_in;     // clamped requested high time, 1..n_in-1

    // Clamp the requested high time so the output always toggles within a period.
    always_comb begin
        h_in = duty_val;
        if (duty_val < ONE) begin
            h_in = ONE;
        end else if (duty_val > n_in - ONE) begin
            h_in = n_in - ONE;
        end
    end

    // Duty shadow register: loaded only at period boundaries, like the divisor.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_act <= RST_HIGH;
        end else if (enable && boundary) begin
            h_act <= h_in;
        end
    end

    assign h_cur = h_act;
`else
    assign h_cur = div_act >> 1;
`endif

    // Divisor clamp and period-boundary detection.
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment) so no latch is inferred.
    always_comb begin
        n_in     = (div_val < TWO) ? TWO : div_val;
        cnt_inc  = cnt + ONE;
        boundary = (cnt == div_act - ONE);
    end

    // Counter, shadow divisor and registered outputs; reset wins over enable.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= RST_CNT;
            div_act <= RST_DIV;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (enable) begin
            if (boundary) begin
                // New period: high time is at least 1, so clk_out always rises here.
                cnt     <= '0;
                div_act <= n_in;
                tick    <= 1'b1;
                clk_out <= 1'b1;
            end else begin
                cnt     <= cnt_inc;
                tick    <= 1'b0;
                clk_out <= (cnt_inc < h_cur);
            end
        end else begin
            // Frozen: hold position and level, but never repeat the strobe.
            tick <= 1'b0;
        end
    end

    assign cur_div = div_act;

endmodule

// File: tb/tb_freq_div_n.sv
// tb_freq_div_n: directed self-checking bench for freq_div_n (WIDTH=8,
// DEFAULT_DIV=2). Expected waveforms are hand-computed bit patterns, written
// MSB-first in the order the cycles occur. Outputs are checked 5 ns after
// each rising edge of a 40 ns clock; inputs change at the same point.
module tb_freq_div_n;

    localparam int WIDTH = 8;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] div_val;
`ifdef FREQ_DIV_DUTY_EN
    logic [WIDTH-1:0] duty_val;
`endif
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;

    int total = 0;
    int bad   = 0;

    freq_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable),
        .div_val (div_val),
`ifdef FREQ_DIV_DUTY_EN
        .duty_val(duty_val),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .cur_div (cur_div)
    );

    always #20 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #5;
    endtask

    // Run n cycles; cycle i expects clk_out=clk_pat[n-1-i], tick=tick_pat[n-1-i],
    // cur_div=div_a before cycle sw and div_b from cycle sw on.
    task automatic run_seq(input string tag, input int n,
                           input logic [15:0] clk_pat, input logic [15:0] tick_pat,
                           input int div_a, input int div_b, input int sw);
        for (int i = 0; i < n; i++) begin
            cyc();
            check($sformatf("%s.clk_out[%0d]", tag, i), 32'(clk_out), 32'(clk_pat[n-1-i]));
            check($sformatf("%s.tick[%0d]", tag, i), 32'(tick), 32'(tick_pat[n-1-i]));
            check($sformatf("%s.cur_div[%0d]", tag, i), 32'(cur_div),
                  (i < sw) ? 32'(div_a) : 32'(div_b));
        end
    endtask

    initial begin
        int high_cnt;
        int tick_cnt;

        // 1: reset 3 cycles with div 2, then 1,0,1,0 with tick on each rise.
        reset   = 1'b1;
        enable  = 1'b1;
        div_val = 8'd2;
`ifdef FREQ_DIV_DUTY_EN
        duty_val = 8'd1;
`endif
        repeat (3) cyc();
        check("rst.clk_out", 32'(clk_out), 32'd0);
        check("rst.tick", 32'(tick), 32'd0);
        check("rst.cur_div", 32'(cur_div), 32'd2);
        reset = 1'b0;
        run_seq("div2", 4, 16'b1010, 16'b1010, 2, 2, 0);

        // 2: N=5 -> high 2, low 3; cur_div switches on the boundary edge.
        div_val = 8'd5;
        run_seq("div5", 10, 16'b1100011000, 16'b1000010000, 5, 5, 0);

        // 3: N=8, then div_val=3 at cnt=2: old period finishes (5 more cycles).
        div_val = 8'd8;
        run_seq("div8", 3, 16'b111, 16'b100, 8, 8, 0);
        div_val = 8'd3;
        run_seq("shrink", 9, 16'b100001001, 16'b000001001, 8, 3, 5);

        // 4: div_val 0 and 1 clamp to 2.
        div_val = 8'd0;
        run_seq("div0", 6, 16'b001010, 16'b001010, 3, 2, 2);
        div_val = 8'd1;
        run_seq("div1", 4, 16'b1010, 16'b1010, 2, 2, 0);

        // 5: N=6 (high 3), freeze at cnt=3 for 4 cycles, resume at cnt=4.
        div_val = 8'd6;
        run_seq("div6", 4, 16'b1110, 16'b1000, 6, 6, 0);
        enable = 1'b0;
        run_seq("freeze", 4, 16'b0000, 16'b0000, 6, 6, 0);
        enable = 1'b1;
        run_seq("resume", 3, 16'b001, 16'b001, 6, 6, 0);
        // Freeze right after a boundary: tick must drop while clk_out holds high.
        enable = 1'b0;
        run_seq("frz_tick", 2, 16'b11, 16'b00, 6, 6, 0);
        enable = 1'b1;
        run_seq("resume2", 2, 16'b11, 16'b00, 6, 6, 0);
        // Mid-period reset returns to reset state on the next edge.
        reset   = 1'b1;
        div_val = 8'd4;
        run_seq("rst_mid", 1, 16'b0, 16'b0, 2, 2, 0);
        reset = 1'b0;
        run_seq("div4", 5, 16'b11001, 16'b10001, 4, 4, 0);

        // Maximum divisor 255: high 127 cycles, tick exactly 255 cycles apart.
        div_val = 8'd255;
        run_seq("to255", 4, 16'b1001, 16'b0001, 4, 255, 3);
        high_cnt = 0;
        tick_cnt = 0;
        for (int i = 0; i < 254; i++) begin
            cyc();
            if (clk_out === 1'b1) high_cnt++;
            if (tick === 1'b1) tick_cnt++;
        end
        check("div255.high_cycles", 32'(high_cnt + 1), 32'd127);
        check("div255.ticks_mid", 32'(tick_cnt), 32'd0);
        run_seq("div255.wrap", 1, 16'b1, 16'b1, 255, 255, 0);

`ifdef FREQ_DIV_DUTY_EN
        // 6: programmable duty at N=10: high 3, then 1 (duty 0), then 9 (duty 12).
        reset    = 1'b1;
        div_val  = 8'd10;
        duty_val = 8'd3;
        cyc();
        reset = 1'b0;
        run_seq("duty3.first", 1, 16'b1, 16'b1, 10, 10, 0);
        duty_val = 8'd0;
        run_seq("duty3", 10, 16'b1100000001, 16'b0000000001, 10, 10, 0);
        duty_val = 8'd12;
        run_seq("duty0", 10, 16'b0000000001, 16'b0000000001, 10, 10, 0);
        run_seq("duty12", 10, 16'b1111111101, 16'b0000000001, 10, 10, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
